data_mem_responder: RTL and testbench

Memory-side responder for the core's load/store interface. It accepts the `memRead`/`memWrite` strobes and the `isByte`/`isHalf`/`isWord` size selects that the controller drives, and performs the access on an internal byte-addressable RAM with a fixed programmable latency. It returns sign- or zero-extended load data, or commits store bytes, and raises a one-cycle `ready` when the access completes. It sits beside `Data_path` and lets the multicycle controller wait on `ready` instead of assuming single-cycle memory.

---
 rtl/data_mem_responder_pkg.sv | 54 +++++
 rtl/data_mem_responder_if.sv | 27 ++
 rtl/data_mem_responder_byte_ram.sv | 30 +++
 rtl/data_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and lane helpers for the data memory responder.
// Size codes, FSM states, byte-enable generation and load/store lane alignment.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001 << off;
      SZ_H:    m = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate right-aligned store data so every candidate lane carries it.
  function automatic logic [31:0] store_align(input logic [31:0] data, input logic [1:0] size);
    logic [31:0] r;
    case (size)
      SZ_B:    r = {4{data[7:0]}};
      SZ_H:    r = {2{data[15:0]}};
      SZ_W:    r = data;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = uns ? {24'h00_0000, b} : {{24{b[7]}}, b};
      SZ_H:    r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      SZ_W:    r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store bus between the multicycle controller (master) and the memory responder (slave).
interface data_mem_responder_if #(
  parameter int WIDTH = 32
);
  logic             memRead;
  logic             memWrite;
  logic             isByte;
  logic             isHalf;
  logic             isWord;
  logic             isUnsigned;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             ready;
  logic             busy;
  logic             err;

  modport master (
    output memRead, memWrite, isByte, isHalf, isWord, isUnsigned, addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  memRead, memWrite, isByte, isHalf, isWord, isUnsigned, addr, wdata,
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/data_mem_responder_byte_ram.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// Contents are deliberately left unreset.
module byte_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [AW-1:0] wordAddr,
  input  logic [31:0]   wdata,
  output logic [31:0]   q
);
  logic [3:0][7:0] mem [DEPTH_WORDS];

  // Byte-enabled write and registered read share one address.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[wordAddr][i] <= wdata[i*8 +: 8];
        end
      end
    end
    if (re) begin
      q <= mem[wordAddr];
    end
  end
endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts one load/store, waits a fixed latency, then
// commits or reads the RAM and pulses ready (with err if the request was illegal).
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic                clk,
  input logic                reset,
  data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  state_t           state;
  state_t           stateNext;
  logic             accept;
  logic             commit;

  logic             anyReq;
  logic             reqBad;
  logic [1:0]       sizeIn;

  logic [3:0]       cnt;
  logic             reqIsWrite;
  logic             reqErr;
  logic             reqUns;
  logic [1:0]       reqSize;
  logic [1:0]       reqOff;
  logic [AW-1:0]    reqWordIdx;
  logic [WIDTH-1:0] reqWdata;

  logic             respReady;
  logic             respErr;
  logic             respBusy;

  logic             rdValid;
  logic [1:0]       rdSize;
  logic [1:0]       rdOff;
  logic             rdUns;

  logic             ramWe;
  logic             ramRe;
  logic [31:0]      ramQ;

  // Classify the incoming request; all error causes are resolved at acceptance.
  always_comb begin
    anyReq = bus.memRead | bus.memWrite;
    if (bus.isWord) begin
      sizeIn = SZ_W;
    end else if (bus.isHalf) begin
      sizeIn = SZ_H;
    end else begin
      sizeIn = SZ_B;
    end
    reqBad = (bus.memRead & bus.memWrite)
           | !$onehot({bus.isByte, bus.isHalf, bus.isWord})
           | (bus.isHalf & bus.addr[0])
           | (bus.isWord & (bus.addr[1:0] != 2'b00))
           | ((bus.addr >> 2) >= WIDTH'(DEPTH_WORDS));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic; strobes are only looked at in IDLE.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) begin
          stateNext = ACCESS;
          accept    = 1'b1;
        end else begin
          stateNext = IDLE;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          stateNext = RESP;
          commit    = 1'b1;
        end else begin
          stateNext = ACCESS;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Request latch, latency counter and response flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= 4'd0;
      reqIsWrite <= 1'b0;
      reqErr     <= 1'b0;
      reqUns     <= 1'b0;
      reqSize    <= SZ_B;
      reqOff     <= 2'b00;
      reqWordIdx <= '0;
      reqWdata   <= '0;
      respReady  <= 1'b0;
      respErr    <= 1'b0;
      respBusy   <= 1'b0;
    end else begin
      respReady <= commit;
      respErr   <= commit & reqErr;
      respBusy  <= (stateNext != IDLE);
      if (accept) begin
        cnt        <= 4'(LATENCY - 1);
        reqIsWrite <= bus.memWrite;
        reqErr     <= reqBad;
        reqUns     <= bus.isUnsigned;
        reqSize    <= sizeIn;
        reqOff     <= bus.addr[1:0];
        reqWordIdx <= bus.addr[AW+1:2];
        reqWdata   <= bus.wdata;
      end else if ((state == ACCESS) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Remember how the last good load must be extracted; rdata follows only that.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdValid <= 1'b0;
      rdSize  <= SZ_B;
      rdOff   <= 2'b00;
      rdUns   <= 1'b0;
    end else if (ramRe) begin
      rdValid <= 1'b1;
      rdSize  <= reqSize;
      rdOff   <= reqOff;
      rdUns   <= reqUns;
    end
  end

  // Reset on the commit edge must win, so it gates the RAM strobes directly.
  assign ramWe = commit & !reqErr & reqIsWrite & !reset;
  assign ramRe = commit & !reqErr & !reqIsWrite & !reset;

  byte_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) uRam (
    .clk      (clk),
    .we       (ramWe),
    .re       (ramRe),
    .be       (lane_mask(reqSize, reqOff)),
    .wordAddr (reqWordIdx),
    .wdata    (store_align(reqWdata, reqSize)),
    .q        (ramQ)
  );

  // Lane extraction on the registered read word.
  always_comb begin
    if (rdValid) begin
      bus.rdata = load_extend(ramQ, rdSize, rdOff, rdUns);
    end else begin
      bus.rdata = '0;
    end
  end

  assign bus.ready = respReady;
  assign bus.err   = respErr;
  assign bus.busy  = respBusy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a byte-array
// reference model of the memory and the last load result.
module tb_data_mem_responder;
  localparam int DEPTH   = 1024;
  localparam int LAT     = 2;
  localparam int REGION  = 128;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if #(.WIDTH(32)) bus ();

  data_mem_responder #(
    .WIDTH       (32),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          nVec = 0;
  int          nBad = 0;
  logic [7:0]  mdl [REGION];
  logic [31:0] mdlRdata = 32'h0000_0000;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: memory is a little-endian byte array; errors leave it and rdata untouched.
  task automatic modelApply(input bit rd, input bit wr, input bit b, input bit h, input bit w,
                            input bit uns, input logic [31:0] a, input logic [31:0] wd,
                            output bit expErr);
    int          nBytes;
    logic [31:0] v;
    nBytes = b ? 1 : (h ? 2 : 4);
    expErr = 1'b0;
    if (rd && wr) expErr = 1'b1;
    if ((int'(b) + int'(h) + int'(w)) != 1) expErr = 1'b1;
    if ((a % nBytes) != 0) expErr = 1'b1;
    if ((a / 4) >= DEPTH) expErr = 1'b1;
    if (!expErr) begin
      if (wr) begin
        for (int i = 0; i < nBytes; i++) mdl[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0000_0000;
        for (int i = 0; i < nBytes; i++) v = v | (32'(mdl[int'(a) + i]) << (8*i));
        if (!uns && nBytes < 4 && v[8*nBytes-1]) v = v | (32'hFFFF_FFFF << (8*nBytes));
        mdlRdata = v;
      end
    end
  endtask

  task automatic driveReq(input bit rd, input bit wr, input bit b, input bit h, input bit w,
                          input bit uns, input logic [31:0] a, input logic [31:0] wd);
    bus.memRead = rd; bus.memWrite = wr;
    bus.isByte = b; bus.isHalf = h; bus.isWord = w; bus.isUnsigned = uns;
    bus.addr = a; bus.wdata = wd;
  endtask

  task automatic dropReq();
    driveReq(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
  endtask

  // One full transaction with the requester holding strobes until ready.
  task automatic doAccess(input bit rd, input bit wr, input bit b, input bit h, input bit w,
                          input bit uns, input logic [31:0] a, input logic [31:0] wd,
                          input bit relReset);
    bit expErr;
    int cyc;
    @(negedge clk);
    if (relReset) reset = 1'b0;
    driveReq(rd, wr, b, h, w, uns, a, wd);
    modelApply(rd, wr, b, h, w, uns, a, wd, expErr);
    @(posedge clk); #1;
    checkEq("busy_after_accept", 32'(bus.busy), 32'd1);
    cyc = 0;
    while (!bus.ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkEq("ready_latency", cyc, LAT);
    checkEq("err", 32'(bus.err), 32'(expErr));
    checkEq("rdata", bus.rdata, mdlRdata);
    @(negedge clk);
    dropReq();
    @(posedge clk); #1;
    checkEq("ready_pulse_end", 32'(bus.ready), 32'd0);
    checkEq("busy_end", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bit          e;
    bit          rd, wr, b, h, w;
    int          s, cyc, extra;
    logic [31:0] a;

    dropReq();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkEq("reset_rdata", bus.rdata, 32'h0000_0000);
    checkEq("reset_ready", 32'(bus.ready), 32'd0);
    checkEq("reset_busy", 32'(bus.busy), 32'd0);
    checkEq("reset_err", 32'(bus.err), 32'd0);

    // Seed the modelled region; the first store lands on the first post-reset edge.
    for (int i = 0; i < REGION / 4; i++)
      doAccess(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'(4*i), $urandom, i == 0);

    doAccess(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
    doAccess(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    checkEq("word_roundtrip", bus.rdata, 32'hDEAD_BEEF);
    doAccess(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h13, 32'h80, 1'b0);
    doAccess(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h13, 32'h0, 1'b0);
    checkEq("lb_signed", bus.rdata, 32'hFFFF_FF80);
    doAccess(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h13, 32'h0, 1'b0);
    checkEq("lbu", bus.rdata, 32'h0000_0080);
    doAccess(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    checkEq("word_after_sb", bus.rdata, 32'h80AD_BEEF);
    doAccess(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h12, 32'h1234, 1'b0);
    doAccess(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    checkEq("word_after_sh", bus.rdata, 32'h1234_BEEF);

    // Rejected requests: ready+err, no store, rdata held at 0x1234BEEF.
    doAccess(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h11, 32'h0, 1'b0);
    doAccess(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h22, 32'hFFFF_FFFF, 1'b0);
    doAccess(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'(4*DEPTH), 32'h1, 1'b0);
    doAccess(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h2, 1'b0);
    doAccess(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h3, 1'b0);
    checkEq("rdata_held_after_errors", bus.rdata, 32'h1234_BEEF);
    doAccess(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    doAccess(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    checkEq("mem_kept_after_errors", bus.rdata, 32'h1234_BEEF);

    for (int n = 0; n < 150; n++) begin
      s  = $urandom_range(0, 99);
      rd = (s < 5) ? 1'b1 : s[0];
      wr = (s < 5) ? 1'b1 : !s[0];
      s  = $urandom_range(0, 19);
      b  = (s == 0) || (s == 2) || (s >= 3 && s % 3 == 0);
      h  = (s == 0) || (s == 2) || (s >= 3 && s % 3 == 1);
      w  = (s == 2) || (s >= 3 && s % 3 == 2);
      if ($urandom_range(0, 19) == 0) a = 32'(4*DEPTH) + 32'($urandom_range(0, 255));
      else a = 32'($urandom_range(0, REGION - 1));
      doAccess(rd, wr, b, h, w, 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
    end

    // Single-cycle read strobe, then a write pulse during ACCESS that must be ignored.
    @(negedge clk);
    driveReq(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h08, 32'h0);
    modelApply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h08, 32'h0, e);
    @(posedge clk);
    @(negedge clk);
    driveReq(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0C, 32'hA5A5_A5A5);
    @(negedge clk);
    dropReq();
    cyc = 0;
    while (!bus.ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkEq("pulse_ready_seen", 32'(bus.ready), 32'd1);
    checkEq("pulse_rdata", bus.rdata, mdlRdata);
    @(posedge clk);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.busy || bus.ready) extra++;
    end
    checkEq("no_second_access", extra, 0);
    doAccess(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0C, 32'h0, 1'b0);

    // Reset one cycle before the commit edge, then exactly on it.
    for (int off = 1; off <= LAT; off++) begin
      @(negedge clk);
      driveReq(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h55);
      @(posedge clk);
      repeat (off - 1) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      dropReq();
      @(posedge clk); #1;
      mdlRdata = 32'h0000_0000;
      checkEq("abort_ready", 32'(bus.ready), 32'd0);
      checkEq("abort_busy", 32'(bus.busy), 32'd0);
      checkEq("abort_rdata", bus.rdata, 32'h0000_0000);
      @(negedge clk);
      reset = 1'b0;
      extra = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (bus.ready) extra++;
      end
      checkEq("abort_no_ready", extra, 0);
      doAccess(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
